edge_detect_multi: RTL and testbench
====================================

Name: edge_detect_multi

Overview:
- Parametrised multi-channel edge detector.
- Each channel samples an asynchronous level input through a configurable synchroniser and detects rising, falling or both edges, selected per channel at run time.
- Each detection produces a one-cycle registered pulse and sets a sticky pending bit. Pending bits are cleared by a write-1-to-clear mask and combined into a maskable interrupt.
- Sits between external/status level signals and the control/interrupt logic.

Parameters:
- WIDTH, 4, number of independent channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=0; 0 = input already synchronous).
- CNT_W, 8, width of each per-channel event counter (only used with EDGE_DETECT_CNT_EN).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- data_in  input  WIDTH  level inputs, one per channel
- mode_i  input  2*WIDTH  per-channel mode, bits [2k+1:2k]: 00 off, 01 rise, 10 fall, 11 both
- clr_i  input  WIDTH  write-1-to-clear pending (and counter), single-cycle per bit
- irq_en_i  input  WIDTH  per-channel interrupt enable
- pulse_o  output  WIDTH  one-cycle registered edge pulse per channel
- pending_o  output  WIDTH  sticky pending flags
- irq_o  output  1  registered interrupt
- cnt_o  output  WIDTH*CNT_W  per-channel event counts (present only with EDGE_DETECT_CNT_EN)

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0, clear all synchroniser flops, history flops, pulse_o, pending_o, irq_o and cnt_o to 0.
- Per channel k:
  - s_k = data_in[k] after SYNC_STAGES flops.
  - h_k = s_k delayed one cycle.
  - rise = s_k & ~h_k; fall = ~s_k & h_k.
  - det_k = (mode[0] & rise) | (mode[1] & fall), evaluated with the mode_i value present in the same cycle.
- pulse_o[k] <= det_k. A change on data_in[k] that is stable before clock edge n produces pulse_o high for exactly one cycle following edge n+SYNC_STAGES, i.e. latency SYNC_STAGES+1 edges.
- Back-to-back toggles each cycle in mode 11 give pulse_o high on consecutive cycles. No pulses are merged or dropped.
- Pending: pending[k] <= det_k | (pending[k] & ~clr_i[k]). When det_k and clr_i[k] occur in the same cycle, set wins.
- irq_o <= |(pending_next & irq_en_i), where pending_next is the value being loaded into pending. irq_o therefore rises in the same cycle pending_o rises.
- irq_o falls the cycle after the last enabled pending bit is cleared, or immediately when irq_en_i is deasserted (registered, one cycle).
- Mode 00 suppresses detection only. Synchroniser and history flops keep tracking, so re-enabling a mode does not produce a stale edge.
- Post-reset boundary: h_k resets to 0. If the input is high at reset release, a rising edge is detected once s_k goes high. This is intentional and matches the existing power-up behaviour.
- Reset asserted mid-operation: all state clears immediately; pending pulses and interrupts are lost.

Optional Feature:
- Macro EDGE_DETECT_CNT_EN.
- When defined:
  - Each channel has a CNT_W-bit counter, incremented on det_k and saturating at all-ones.
  - clr_i[k] zeroes the counter. A simultaneous clr_i[k] and det_k loads 1.
  - Port cnt_o exists and reflects the counters.
- When undefined: no counters and no cnt_o port; all other behaviour is identical.

Decomposition:
- Package edge_detect_pkg:
  - typedef enum edge_mode_e (EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11).
  - MODE_W=2 constant.
- Sub-module edge_detect_chan: one channel containing synchroniser, history, detect, pending and optional counter; it outputs pulse and pending. The top generates WIDTH instances and builds irq_o.

Test Plan (WIDTH=4, SYNC_STAGES=2, CNT_W=8):
- Reset with data_in=4'hF and mode 01 on all channels; release reset -> pulse_o=4'hF for exactly one cycle, 3 edges after release; pending_o=4'hF.
- Channel 0 in mode 10: drive 1 then 0 -> no pulse on the rise; one pulse 3 cycles after the fall; channel 1 in mode 00 with the same stimulus -> no pulse, no pending.
- Channel 2 in mode 11, data_in[2] toggling every cycle for 6 cycles -> 6 consecutive pulse_o[2] cycles.
- pending_o[3]=1, irq_en_i=4'h8: irq_o=1; pulse clr_i[3] -> pending_o[3]=0 and irq_o=0 the following cycle; clr_i[3] coinciding with a new det -> pending stays 1.
- Assert rst_n low asynchronously between clock edges while pending and irq are set -> all outputs 0 before the next clock edge.
- EDGE_DETECT_CNT_EN defined: 300 rising edges on channel 0 -> cnt_o[7:0]=8'hFF (saturated); clr_i[0] together with an edge -> count 1.

Source files
------------

// File: rtl/edge_detect_pkg.sv
// edge_detect_pkg: shared mode encoding and widths for the multi-channel edge detector.
package edge_detect_pkg;
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;
endpackage

// File: rtl/edge_detect_chan.sv
// edge_detect_chan: one channel of synchroniser, history, edge detect, sticky pending and optional counter.
// Counter and cnt_o exist only when EDGE_DETECT_CNT_EN is defined.
module edge_detect_chan
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              clr_i,
  output logic              pulse_o,
  output logic              pending_o,
  output logic              pending_d_o
`ifdef EDGE_DETECT_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt_o
`endif
);
  logic s, h_q, h_d, pulse_q, pulse_d, pending_q, pending_d, rise, fall, det_rise, det_fall;
  edge_mode_e mode;
  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = d_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES:0]   sync_w;
    assign sync_w = {sync_q, d_i};
    assign sync_d = sync_w[SYNC_STAGES-1:0];
    assign s      = sync_q[SYNC_STAGES-1];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync_q <= '0;
      else        sync_q <= sync_d;
  end
  // History keeps tracking in EDGE_OFF so re-enabling never sees a stale edge.
  always_comb begin
    mode      = edge_mode_e'(mode_i);
    h_d       = s;
    rise      = s & ~h_q;
    fall      = ~s & h_q;
    det_rise  = (mode == EDGE_RISE || mode == EDGE_BOTH) && rise;
    det_fall  = (mode == EDGE_FALL || mode == EDGE_BOTH) && fall;
    pulse_d   = det_rise | det_fall;
    pending_d = pulse_d | (pending_q & ~clr_i);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h_q       <= 1'b0;
      pulse_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      h_q       <= h_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
    end
  assign pulse_o     = pulse_q;
  assign pending_o   = pending_q;
  assign pending_d_o = pending_d;
`ifdef EDGE_DETECT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Clear wins over increment but still counts a coincident edge.
  always_comb
    cnt_d = clr_i ? CNT_W'(pulse_d) : (pulse_d && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
`endif
endmodule

// File: rtl/edge_detect_multi.sv
// edge_detect_multi: WIDTH-channel edge detector with sticky pending flags and a maskable registered irq.
// Define EDGE_DETECT_CNT_EN to add saturating per-channel event counters on cnt_o.
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        data_in,
  input  logic [MODE_W*WIDTH-1:0] mode_i,
  input  logic [WIDTH-1:0]        clr_i,
  input  logic [WIDTH-1:0]        irq_en_i,
  output logic [WIDTH-1:0]        pulse_o,
  output logic [WIDTH-1:0]        pending_o,
  output logic                    irq_o
`ifdef EDGE_DETECT_CNT_EN
  ,
  output logic [WIDTH*CNT_W-1:0]  cnt_o
`endif
);
  logic [WIDTH-1:0] pending_d;
  logic             irq_q, irq_d;
  if (WIDTH < 1 || SYNC_STAGES < 0 || CNT_W < 1) begin : g_param_err
    $error("edge_detect_multi: illegal parameter value");
  end
  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    edge_detect_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .d_i        (data_in[g]),
      .mode_i     (mode_i[MODE_W*g +: MODE_W]),
      .clr_i      (clr_i[g]),
      .pulse_o    (pulse_o[g]),
      .pending_o  (pending_o[g]),
      .pending_d_o(pending_d[g])
`ifdef EDGE_DETECT_CNT_EN
      ,
      .cnt_o      (cnt_o[CNT_W*g +: CNT_W])
`endif
    );
  end
  // Built from the next pending value so irq rises with pending_o.
  always_comb irq_d = |(pending_d & irq_en_i);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  assign irq_o = irq_q;
endmodule

// File: tb/tb_edge_detect_multi.sv
// tb_edge_detect_multi: directed self-checking bench for edge_detect_multi (WIDTH=4, SYNC_STAGES=2, CNT_W=8).
module tb_edge_detect_multi;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] data_in, clr_i, irq_en_i, pulse_o, pending_o;
  logic [7:0] mode_i;
  logic       irq_o;
  int         checks = 0, errors = 0;
`ifdef EDGE_DETECT_CNT_EN
  logic [31:0] cnt_o;
`endif
  edge_detect_multi #(.WIDTH(4), .SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .mode_i   (mode_i),
    .clr_i    (clr_i),
    .irq_en_i (irq_en_i),
    .pulse_o  (pulse_o),
    .pending_o(pending_o),
    .irq_o    (irq_o)
`ifdef EDGE_DETECT_CNT_EN
    ,
    .cnt_o    (cnt_o)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic clear_all;
    clr_i = 4'hF;
    tick();
    clr_i = 4'h0;
    tick();
  endtask
  task automatic test_reset;
    rst_n = 1'b0; data_in = 4'hF; mode_i = 8'h55; clr_i = 4'h0; irq_en_i = 4'h0;
    tick(3);
    checks++;
    if ({pulse_o, pending_o, irq_o} !== 9'h0) begin
      errors++;
      $display("FAIL reset_state: got pulse=%h pending=%h irq=%b, want all 0", pulse_o, pending_o, irq_o);
    end
    rst_n = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      checks++;
      if (pulse_o !== ((t == 3) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL reset_release_pulse t=%0d: got %h, want %h", t, pulse_o, (t == 3) ? 4'hF : 4'h0);
      end
    end
    checks++;
    if (pending_o !== 4'hF) begin
      errors++;
      $display("FAIL reset_release_pending: got %h, want f", pending_o);
    end
    clear_all();
    checks++;
    if (pending_o !== 4'h0) begin
      errors++;
      $display("FAIL clear_all: got %h, want 0", pending_o);
    end
  endtask
  task automatic test_fall_and_off;
    mode_i = 8'h00; data_in = 4'h0;
    tick(4);
    mode_i = 8'h02;
    data_in = 4'h3;
    for (int t = 1; t <= 5; t++) begin
      tick();
      checks++;
      if (pulse_o !== 4'h0) begin
        errors++;
        $display("FAIL fall_mode_rise t=%0d: got %h, want 0", t, pulse_o);
      end
    end
    data_in = 4'h0;
    for (int t = 1; t <= 4; t++) begin
      tick();
      checks++;
      if (pulse_o !== ((t == 3) ? 4'h1 : 4'h0)) begin
        errors++;
        $display("FAIL fall_pulse t=%0d: got %h, want %h", t, pulse_o, (t == 3) ? 4'h1 : 4'h0);
      end
    end
    checks++;
    if (pending_o !== 4'h1) begin
      errors++;
      $display("FAIL fall_pending: got %h, want 1", pending_o);
    end
    clear_all();
  endtask
  task automatic test_back_to_back;
    mode_i = 8'h30;
    for (int t = 0; t < 12; t++) begin
      if (t < 6) data_in[2] = ~data_in[2];
      tick();
      checks++;
      if (pulse_o !== ((t >= 2 && t <= 7) ? 4'h4 : 4'h0)) begin
        errors++;
        $display("FAIL toggle_pulse t=%0d: got %h, want %h", t, pulse_o, (t >= 2 && t <= 7) ? 4'h4 : 4'h0);
      end
    end
    clear_all();
  endtask
  task automatic test_irq;
    mode_i = 8'h40; irq_en_i = 4'h8; data_in = 4'h8;
    tick(3);
    checks++;
    if (pending_o !== 4'h8 || irq_o !== 1'b1) begin
      errors++;
      $display("FAIL irq_rise: got pending=%h irq=%b, want 8/1", pending_o, irq_o);
    end
    clr_i = 4'h8;
    tick();
    clr_i = 4'h0;
    checks++;
    if (pending_o !== 4'h0 || irq_o !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: got pending=%h irq=%b, want 0/0", pending_o, irq_o);
    end
    data_in = 4'h0;
    tick(4);
    data_in = 4'h8;
    tick(2);
    clr_i = 4'h8;
    tick();
    clr_i = 4'h0;
    checks++;
    if (pending_o !== 4'h8 || irq_o !== 1'b1 || pulse_o !== 4'h8) begin
      errors++;
      $display("FAIL set_wins: got pulse=%h pending=%h irq=%b, want 8/8/1", pulse_o, pending_o, irq_o);
    end
    irq_en_i = 4'h0;
    tick();
    checks++;
    if (irq_o !== 1'b0 || pending_o !== 4'h8) begin
      errors++;
      $display("FAIL irq_mask: got pending=%h irq=%b, want 8/0", pending_o, irq_o);
    end
    irq_en_i = 4'h8;
    tick();
    checks++;
    if (irq_o !== 1'b1) begin
      errors++;
      $display("FAIL irq_unmask: got %b, want 1", irq_o);
    end
  endtask
  task automatic test_async_reset;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pulse_o, pending_o, irq_o} !== 9'h0) begin
      errors++;
      $display("FAIL async_reset: got pulse=%h pending=%h irq=%b, want all 0", pulse_o, pending_o, irq_o);
    end
    mode_i = 8'h00; data_in = 4'h0; irq_en_i = 4'h0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
  endtask
`ifdef EDGE_DETECT_CNT_EN
  task automatic test_cnt;
    mode_i = 8'h01;
    checks++;
    if (cnt_o !== 32'h0) begin
      errors++;
      $display("FAIL cnt_reset: got %h, want 0", cnt_o);
    end
    for (int i = 0; i < 300; i++) begin
      data_in[0] = 1'b1;
      tick();
      data_in[0] = 1'b0;
      tick();
    end
    tick(4);
    checks++;
    if (cnt_o[7:0] !== 8'hFF) begin
      errors++;
      $display("FAIL cnt_saturate: got %h, want ff", cnt_o[7:0]);
    end
    data_in[0] = 1'b1;
    tick(2);
    clr_i = 4'h1;
    tick();
    clr_i = 4'h0;
    checks++;
    if (cnt_o[7:0] !== 8'h01) begin
      errors++;
      $display("FAIL cnt_clr_with_edge: got %h, want 01", cnt_o[7:0]);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_fall_and_off();
    test_back_to_back();
    test_irq();
    test_async_reset();
`ifdef EDGE_DETECT_CNT_EN
    test_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
